// File: rtl/read_arbiter.sv
// read_arbiter
//   Shares the AXI read path between M masters and S slaves.
//   - AR side: round-robin arbitration over eligible masters; the target
//     slave is decoded from the address ((addr / SLICE_SIZE) mod S).
//   - Each slave has a small FIFO recording the order in which masters were
//     accepted, so R bursts (returned in acceptance order) are routed back
//     to the right master.
//   - Outstanding reads per master are capped at NUM_OUTSTANDING_TRANS.
//   - One AR transfer and one R burst are routed at a time.
// Ports:
//   clk          clock, rising edge
//   clr          asynchronous active-low reset
//   AR_valid_f   per-master AR valid
//   AR_addr_f    per-master AR address, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   AR_ready_f   per-slave AR ready
//   AR_grant_f   one-hot AR grant to the owning master
//   AR_sel_f     slave index of the current AR owner
//   AR_msel_f    current AR owner index
//   R_valid_f    per-slave R valid
//   R_last_f     per-slave R last
//   R_ready_f    per-master R ready
//   R_grant_m_f  one-hot R grant to the destination master
//   R_grant_s_f  one-hot R grant to the source slave
//   R_msel_f     destination master index
//   R_ssel_f     source slave index
module read_arbiter #(
  parameter int          M                     = 2,
  parameter int          S                     = 2,
  parameter int          NUM_OUTSTANDING_TRANS = 2,
  parameter int          ADDR_WIDTH            = 32,
  parameter int          SLV_DEPTH             = 4,
  parameter logic [31:0] SLICE_SIZE            = 32'h00010000
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [M-1:0]            AR_valid_f,
  input  logic [M*ADDR_WIDTH-1:0] AR_addr_f,
  input  logic [S-1:0]            AR_ready_f,
  output logic [M-1:0]            AR_grant_f,
  output logic [$clog2(S)-1:0]    AR_sel_f,
  output logic [$clog2(M)-1:0]    AR_msel_f,
  input  logic [S-1:0]            R_valid_f,
  input  logic [S-1:0]            R_last_f,
  input  logic [M-1:0]            R_ready_f,
  output logic [M-1:0]            R_grant_m_f,
  output logic [S-1:0]            R_grant_s_f,
  output logic [$clog2(M)-1:0]    R_msel_f,
  output logic [$clog2(S)-1:0]    R_ssel_f
);

  localparam int MW  = $clog2(M);
  localparam int SW  = $clog2(S);
  localparam int CW  = $clog2(NUM_OUTSTANDING_TRANS + 1);
  localparam int PW  = (SLV_DEPTH > 1) ? $clog2(SLV_DEPTH) : 1;
  localparam int FCW = $clog2(SLV_DEPTH + 1);

  localparam logic [ADDR_WIDTH-1:0] SLICE_W = ADDR_WIDTH'(SLICE_SIZE);
  localparam logic [ADDR_WIDTH-1:0] S_W     = ADDR_WIDTH'(S);
  localparam logic [CW-1:0]         LIM_C   = CW'(NUM_OUTSTANDING_TRANS);
  localparam logic [FCW-1:0]        FULL_C  = FCW'(SLV_DEPTH);
  localparam logic [PW-1:0]         PTR_TOP = PW'(SLV_DEPTH - 1);

  typedef enum logic {AR_IDLE, AR_ALLOW} ar_state_t;
  typedef enum logic {R_IDLE, R_ALLOW}   r_state_t;

  // AR FSM state
  ar_state_t      ar_state_reg, ar_state_next;
  logic [MW-1:0]  ar_owner_reg, ar_owner_next;
  logic [SW-1:0]  ar_slv_reg, ar_slv_next;
  logic [MW-1:0]  ar_ptr_reg, ar_ptr_next;
  logic           ar_push;
  logic           ar_found;
  logic [MW-1:0]  ar_cand;

  // R FSM state
  r_state_t       r_state_reg, r_state_next;
  logic [SW-1:0]  r_slv_reg, r_slv_next;
  logic [MW-1:0]  r_mst_reg, r_mst_next;
  logic [SW-1:0]  r_ptr_reg, r_ptr_next;
  logic           r_pop;
  logic           r_found;
  logic [SW-1:0]  r_cand;

  // Per-master / per-slave bookkeeping
  logic [SW-1:0]  dec_sel [M];
  logic [M-1:0]   ar_elig;
  logic [CW-1:0]  out_cnt [M];
  logic [PW-1:0]  fifo_wr_ptr [S];
  logic [MW-1:0]  fifo_head [S];
  logic [S-1:0]   fifo_full;
  logic [S-1:0]   fifo_empty;
  logic [MW-1:0]  fifo_mem [S][SLV_DEPTH];

  // Address decode and AR eligibility per master
  generate
    for (genvar gi = 0; gi < M; gi++) begin : g_dec
      logic [ADDR_WIDTH-1:0] slice_idx;
      assign slice_idx   = (AR_addr_f[gi*ADDR_WIDTH +: ADDR_WIDTH] / SLICE_W) % S_W;
      assign dec_sel[gi] = slice_idx[SW-1:0];
      assign ar_elig[gi] = AR_valid_f[gi] & (out_cnt[gi] < LIM_C) & ~fifo_full[dec_sel[gi]];
    end
  endgenerate

  // Outstanding counters; simultaneous inc/dec cancel out
  generate
    for (genvar gi = 0; gi < M; gi++) begin : g_out
      logic [CW-1:0] cnt_reg;
      logic          inc_en;
      logic          dec_en;
      assign inc_en = ar_push & (ar_owner_reg == MW'(gi));
      assign dec_en = r_pop & (r_mst_reg == MW'(gi));
      always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
          cnt_reg <= '0;
        end else if (inc_en & ~dec_en) begin
          cnt_reg <= cnt_reg + CW'(1);
        end else if (dec_en & ~inc_en) begin
          cnt_reg <= cnt_reg - CW'(1);
        end
      end
      assign out_cnt[gi] = cnt_reg;
    end
  endgenerate

  // Per-slave order FIFO pointers and counts
  generate
    for (genvar gi = 0; gi < S; gi++) begin : g_fifo
      logic [PW-1:0]  wr_ptr_reg;
      logic [PW-1:0]  rd_ptr_reg;
      logic [FCW-1:0] cnt_reg;
      logic           push_en;
      logic           pop_en;
      assign push_en = ar_push & (ar_slv_reg == SW'(gi));
      assign pop_en  = r_pop & (r_slv_reg == SW'(gi));
      always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          cnt_reg    <= '0;
        end else begin
          if (push_en) begin
            wr_ptr_reg <= (wr_ptr_reg == PTR_TOP) ? '0 : wr_ptr_reg + PW'(1);
          end
          if (pop_en) begin
            rd_ptr_reg <= (rd_ptr_reg == PTR_TOP) ? '0 : rd_ptr_reg + PW'(1);
          end
          if (push_en & ~pop_en) begin
            cnt_reg <= cnt_reg + FCW'(1);
          end else if (pop_en & ~push_en) begin
            cnt_reg <= cnt_reg - FCW'(1);
          end
        end
      end
      assign fifo_wr_ptr[gi] = wr_ptr_reg;
      assign fifo_head[gi]   = fifo_mem[gi][rd_ptr_reg];
      assign fifo_full[gi]   = (cnt_reg == FULL_C);
      assign fifo_empty[gi]  = (cnt_reg == '0);
    end
  endgenerate

  // FIFO storage; contents are only meaningful below the count, so no reset
  always_ff @(posedge clk) begin
    if (ar_push) begin
      fifo_mem[ar_slv_reg][fifo_wr_ptr[ar_slv_reg]] <= ar_owner_reg;
    end
  end

  // ---------------- AR FSM ----------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ar_state_reg <= AR_IDLE;
      ar_owner_reg <= '0;
      ar_slv_reg   <= '0;
      ar_ptr_reg   <= '0;
    end else begin
      ar_state_reg <= ar_state_next;
      ar_owner_reg <= ar_owner_next;
      ar_slv_reg   <= ar_slv_next;
      ar_ptr_reg   <= ar_ptr_next;
    end
  end

  always_comb begin
    ar_state_next = ar_state_reg;
    ar_owner_next = ar_owner_reg;
    ar_slv_next   = ar_slv_reg;
    ar_ptr_next   = ar_ptr_reg;
    ar_push       = 1'b0;
    ar_found      = 1'b0;
    ar_cand       = '0;
    case (ar_state_reg)
      AR_IDLE: begin
        // Rotating scan starting at ar_ptr; first eligible master wins
        for (int k = 0; k < M; k++) begin
          ar_cand = MW'((int'(ar_ptr_reg) + k) % M);
          if (!ar_found && ar_elig[ar_cand]) begin
            ar_found      = 1'b1;
            ar_owner_next = ar_cand;
            ar_slv_next   = dec_sel[ar_cand];
          end
        end
        if (ar_found) begin
          ar_state_next = AR_ALLOW;
        end
      end
      AR_ALLOW: begin
        if (AR_valid_f[ar_owner_reg] & AR_ready_f[ar_slv_reg]) begin
          ar_push       = 1'b1;
          ar_ptr_next   = (ar_owner_reg == MW'(M - 1)) ? '0 : ar_owner_reg + MW'(1);
          ar_state_next = AR_IDLE;
        end else if (!AR_valid_f[ar_owner_reg]) begin
          // Master withdrew its request: release without recording anything
          ar_state_next = AR_IDLE;
        end
      end
      default: ar_state_next = AR_IDLE;
    endcase
  end

  always_comb begin
    AR_grant_f = '0;
    AR_sel_f   = '0;
    AR_msel_f  = '0;
    if (ar_state_reg == AR_ALLOW) begin
      AR_grant_f[ar_owner_reg] = 1'b1;
      AR_sel_f                 = ar_slv_reg;
      AR_msel_f                = ar_owner_reg;
    end
  end

  // ---------------- R FSM ----------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state_reg <= R_IDLE;
      r_slv_reg   <= '0;
      r_mst_reg   <= '0;
      r_ptr_reg   <= '0;
    end else begin
      r_state_reg <= r_state_next;
      r_slv_reg   <= r_slv_next;
      r_mst_reg   <= r_mst_next;
      r_ptr_reg   <= r_ptr_next;
    end
  end

  always_comb begin
    r_state_next = r_state_reg;
    r_slv_next   = r_slv_reg;
    r_mst_next   = r_mst_reg;
    r_ptr_next   = r_ptr_reg;
    r_pop        = 1'b0;
    r_found      = 1'b0;
    r_cand       = '0;
    case (r_state_reg)
      R_IDLE: begin
        // A slave with no recorded read is ignored even if it asserts R_valid
        for (int k = 0; k < S; k++) begin
          r_cand = SW'((int'(r_ptr_reg) + k) % S);
          if (!r_found && R_valid_f[r_cand] && !fifo_empty[r_cand]) begin
            r_found    = 1'b1;
            r_slv_next = r_cand;
            r_mst_next = fifo_head[r_cand];
          end
        end
        if (r_found) begin
          r_state_next = R_ALLOW;
        end
      end
      R_ALLOW: begin
        if (R_valid_f[r_slv_reg] & R_ready_f[r_mst_reg] & R_last_f[r_slv_reg]) begin
          r_pop        = 1'b1;
          r_ptr_next   = (r_slv_reg == SW'(S - 1)) ? '0 : r_slv_reg + SW'(1);
          r_state_next = R_IDLE;
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    R_grant_m_f = '0;
    R_grant_s_f = '0;
    R_msel_f    = '0;
    R_ssel_f    = '0;
    if (r_state_reg == R_ALLOW) begin
      R_grant_m_f[r_mst_reg] = 1'b1;
      R_grant_s_f[r_slv_reg] = 1'b1;
      R_msel_f               = r_mst_reg;
      R_ssel_f               = r_slv_reg;
    end
  end

endmodule

// File: tb/tb_read_arbiter.sv
// Testbench for read_arbiter: three masters (non-power-of-two rotation),
// two slaves, outstanding limit 2, slave FIFO depth 4.
module tb_read_arbiter;

  localparam int M     = 3;
  localparam int S     = 2;
  localparam int LIM   = 2;
  localparam int AW    = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            clr;
  logic [M-1:0]    ar_valid;
  logic [M*AW-1:0] ar_addr;
  logic [S-1:0]    ar_ready;
  logic [M-1:0]    ar_grant;
  logic [0:0]      ar_sel;
  logic [1:0]      ar_msel;
  logic [S-1:0]    r_valid;
  logic [S-1:0]    r_last;
  logic [M-1:0]    r_ready;
  logic [M-1:0]    r_grant_m;
  logic [S-1:0]    r_grant_s;
  logic [1:0]      r_msel;
  logic [0:0]      r_ssel;

  read_arbiter #(
    .M(M), .S(S), .NUM_OUTSTANDING_TRANS(LIM), .ADDR_WIDTH(AW),
    .SLV_DEPTH(DEPTH), .SLICE_SIZE(32'h00010000)
  ) dut (
    .clk(clk), .clr(clr),
    .AR_valid_f(ar_valid), .AR_addr_f(ar_addr), .AR_ready_f(ar_ready),
    .AR_grant_f(ar_grant), .AR_sel_f(ar_sel), .AR_msel_f(ar_msel),
    .R_valid_f(r_valid), .R_last_f(r_last), .R_ready_f(r_ready),
    .R_grant_m_f(r_grant_m), .R_grant_s_f(r_grant_s),
    .R_msel_f(r_msel), .R_ssel_f(r_ssel)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // -1 means "nobody": no current AR owner / no R route.
  int m_ar_own, m_ar_slv, m_ar_ptr;
  int m_r_slv, m_r_mst, m_r_ptr;
  int m_out [M];
  int m_q [S][$];

  function automatic int target(input int i);
    longint unsigned a;
    a = longint'(ar_addr[i*AW +: AW]);
    return int'((a / 64'h10000) % S);
  endfunction

  always @(posedge clk or negedge clr) begin
    int n_own, n_slv, n_aptr, n_rs, n_rm, n_rptr;
    int push_s, push_m, pop_s, pop_m, i, s;
    if (!clr) begin
      m_ar_own = -1; m_ar_slv = -1; m_ar_ptr = 0;
      m_r_slv = -1; m_r_mst = -1; m_r_ptr = 0;
      for (int k = 0; k < M; k++) m_out[k] = 0;
      for (int k = 0; k < S; k++) m_q[k].delete();
    end else begin
      n_own = m_ar_own; n_slv = m_ar_slv; n_aptr = m_ar_ptr;
      n_rs = m_r_slv; n_rm = m_r_mst; n_rptr = m_r_ptr;
      push_s = -1; push_m = -1; pop_s = -1; pop_m = -1;
      if (m_ar_own < 0) begin
        for (int k = 0; k < M; k++) begin
          i = (m_ar_ptr + k) % M;
          if (n_own < 0 && ar_valid[i] && m_out[i] < LIM && m_q[target(i)].size() < DEPTH) begin
            n_own = i; n_slv = target(i);
          end
        end
      end else if (ar_valid[m_ar_own] && ar_ready[m_ar_slv]) begin
        push_s = m_ar_slv; push_m = m_ar_own;
        n_aptr = (m_ar_own + 1) % M; n_own = -1; n_slv = -1;
        $display("AR accept: master %0d -> slave %0d at %0t", m_ar_own, m_ar_slv, $time);
      end else if (!ar_valid[m_ar_own]) begin
        n_own = -1; n_slv = -1;
      end
      if (m_r_slv < 0) begin
        for (int k = 0; k < S; k++) begin
          s = (m_r_ptr + k) % S;
          if (n_rs < 0 && r_valid[s] && m_q[s].size() > 0) begin
            n_rs = s; n_rm = m_q[s][0];
          end
        end
      end else if (r_valid[m_r_slv] && r_ready[m_r_mst] && r_last[m_r_slv]) begin
        pop_s = m_r_slv; pop_m = m_r_mst;
        n_rptr = (m_r_slv + 1) % S; n_rs = -1; n_rm = -1;
        $display("R done: slave %0d -> master %0d at %0t", m_r_slv, m_r_mst, $time);
      end
      if (pop_s >= 0) begin
        void'(m_q[pop_s].pop_front());
        m_out[pop_m]--;
      end
      if (push_s >= 0) begin
        m_q[push_s].push_back(push_m);
        m_out[push_m]++;
      end
      m_ar_own = n_own; m_ar_slv = n_slv; m_ar_ptr = n_aptr;
      m_r_slv = n_rs; m_r_mst = n_rm; m_r_ptr = n_rptr;
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    chk("ar_grant", int'(ar_grant), (m_ar_own >= 0) ? (1 << m_ar_own) : 0);
    chk("ar_sel", int'(ar_sel), (m_ar_own >= 0) ? m_ar_slv : 0);
    chk("ar_msel", int'(ar_msel), (m_ar_own >= 0) ? m_ar_own : 0);
    chk("r_grant_m", int'(r_grant_m), (m_r_slv >= 0) ? (1 << m_r_mst) : 0);
    chk("r_grant_s", int'(r_grant_s), (m_r_slv >= 0) ? (1 << m_r_slv) : 0);
    chk("r_msel", int'(r_msel), (m_r_slv >= 0) ? m_r_mst : 0);
    chk("r_ssel", int'(r_ssel), (m_r_slv >= 0) ? m_r_slv : 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk); #1;
  endtask

  // Issue one read; w = cycles from valid to grant, g/sl = grant and slave seen
  task automatic do_ar(input int m, input logic [31:0] addr, output int w, output int g, output int sl);
    ar_addr[m*AW +: AW] = addr;
    ar_valid[m] = 1'b1;
    w = 0; g = 0; sl = -1;
    do begin
      @(negedge clk); w++;
    end while (!ar_grant[m] && w < 100);
    if (!ar_grant[m]) chk("ar_timeout", 0, 1);
    g = int'(ar_grant); sl = int'(ar_sel);
    @(negedge clk); #1;
    ar_valid[m] = 1'b0;
  endtask

  // Slave s returns a burst of 'beats' beats; reports the routing seen
  task automatic r_burst(input int s, input int beats, output int dst, output int gm,
                         output int gs, output int ncyc);
    int b, t;
    b = 0; t = 0; dst = -1; gm = 0; gs = 0; ncyc = 0;
    r_valid[s] = 1'b1; r_last[s] = 1'b0;
    while (b < beats && t < 200) begin
      @(negedge clk); t++;
      if (r_grant_s[s]) begin
        if (b == 0) begin
          dst = int'(r_msel); gm = int'(r_grant_m); gs = int'(r_grant_s);
        end
        ncyc++;
        #1 r_last[s] = (b == beats - 1);
        b++;
      end
    end
    if (b < beats) chk("r_burst_timeout", b, beats);
    @(negedge clk); #1;
    r_valid[s] = 1'b0; r_last[s] = 1'b0;
  endtask

  initial begin
    int w, g, sl, dst, gm, gs, nc, cnt, t;
    int seq[$];
    clr = 1'b0; ar_valid = '0; ar_addr = '0; ar_ready = '1;
    r_valid = '0; r_last = '0; r_ready = '1;
    repeat (2) @(negedge clk);
    chk("reset_ar_grant", int'(ar_grant), 0);
    chk("reset_r_grant_m", int'(r_grant_m), 0);
    #1 clr = 1'b1;
    step();

    // Single read to slave 1, 4-beat burst
    do_ar(0, 32'h0001_0040, w, g, sl);
    chk("t1_latency", w, 1);
    chk("t1_grant", g, 3'b001);
    chk("t1_sel", sl, 1);
    chk("t1_model_q1", m_q[1].size(), 1);
    r_burst(1, 4, dst, gm, gs, nc);
    chk("t1_r_grant_m", gm, 3'b001);
    chk("t1_r_grant_s", gs, 2'b10);
    chk("t1_beats", nc, 4);
    chk("t1_model_q1_empty", m_q[1].size(), 0);
    chk("t1_model_out0", m_out[0], 0);

    // Bring the AR pointer back to master 0 via master 2
    do_ar(2, 32'h0000_0000, w, g, sl);
    chk("t2_pre_grant", g, 3'b100);
    r_burst(0, 1, dst, gm, gs, nc);
    chk("t2_pre_dst", dst, 2);

    // Round-robin between masters 0 and 1 on slave 0
    ar_addr[0*AW +: AW] = 32'h0000_0100;
    ar_addr[1*AW +: AW] = 32'h0002_0200;
    ar_valid[0] = 1'b1; ar_valid[1] = 1'b1;
    t = 0;
    while (seq.size() < 3 && t < 60) begin
      @(negedge clk); t++;
      if (ar_grant != '0) seq.push_back(int'(ar_msel));
    end
    @(negedge clk); #1;
    ar_valid[0] = 1'b0; ar_valid[1] = 1'b0;
    chk("t2_seq_len", seq.size(), 3);
    if (seq.size() == 3) begin
      chk("t2_rr0", seq[0], 0);
      chk("t2_rr1", seq[1], 1);
      chk("t2_rr2", seq[2], 0);
    end
    chk("t2_model_q0", m_q[0].size(), 3);
    r_burst(0, 2, dst, gm, gs, nc); chk("t2_r_dst0", dst, 0);
    r_burst(0, 3, dst, gm, gs, nc); chk("t2_r_dst1", dst, 1);
    r_burst(0, 1, dst, gm, gs, nc); chk("t2_r_dst2", dst, 0);

    // Outstanding limit on master 1
    do_ar(1, 32'h0000_0300, w, g, sl); chk("t3_a1", w, 1);
    do_ar(1, 32'h0000_0300, w, g, sl); chk("t3_a2", w, 1);
    ar_valid[1] = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (ar_grant != '0) cnt++;
    end
    chk("t3_blocked", cnt, 0);
    r_burst(0, 1, dst, gm, gs, nc); chk("t3_r_dst", dst, 1);
    w = 0;
    do begin
      @(negedge clk); w++;
    end while (!ar_grant[1] && w < 5);
    chk("t3_regrant_within_2", (w <= 2) ? 1 : 0, 1);
    @(negedge clk); #1;
    ar_valid[1] = 1'b0;
    r_burst(0, 2, dst, gm, gs, nc); chk("t3_drain0", dst, 1);
    r_burst(0, 1, dst, gm, gs, nc); chk("t3_drain1", dst, 1);

    // FIFO full on slave 1, then simultaneous push and pop
    do_ar(0, 32'h0001_0000, w, g, sl); chk("t4_sel_a", sl, 1);
    do_ar(0, 32'h0003_0000, w, g, sl); chk("t4_sel_b", sl, 1);
    do_ar(1, 32'h0005_0010, w, g, sl); chk("t4_sel_c", sl, 1);
    do_ar(1, 32'h0001_0020, w, g, sl); chk("t4_sel_d", sl, 1);
    chk("t4_model_full", m_q[1].size(), 4);
    ar_ready[1] = 1'b0;
    ar_addr[2*AW +: AW] = 32'h0007_0000;
    ar_valid[2] = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (ar_grant != '0) cnt++;
    end
    chk("t4_full_blocked", cnt, 0);
    r_burst(1, 2, dst, gm, gs, nc); chk("t4_pop_dst", dst, 0);
    step(); step();
    chk("t4_stalled_grant", int'(ar_grant), 3'b100);
    chk("t4_stalled_sel", int'(ar_sel), 1);
    r_valid[1] = 1'b1; r_last[1] = 1'b1;
    @(negedge clk);
    chk("t4_r_head", int'(r_grant_m), 3'b001);
    #1 ar_ready[1] = 1'b1;
    step();
    r_valid[1] = 1'b0; r_last[1] = 1'b0; ar_valid[2] = 1'b0;
    chk("t4_model_after_pp", m_q[1].size(), 3);
    do_ar(0, 32'h0001_0000, w, g, sl); chk("t4_refill", w, 1);
    ar_valid[2] = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (ar_grant != '0) cnt++;
    end
    chk("t4_full_again", cnt, 0);
    #1 ar_valid[2] = 1'b0;
    step();
    r_burst(1, 1, dst, gm, gs, nc); chk("t4_order0", dst, 1);
    r_burst(1, 1, dst, gm, gs, nc); chk("t4_order1", dst, 1);
    r_burst(1, 1, dst, gm, gs, nc); chk("t4_order2", dst, 2);
    r_burst(1, 1, dst, gm, gs, nc); chk("t4_order3", dst, 0);

    // Spurious R_valid with an empty FIFO
    r_valid[0] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("t5_spurious", int'(r_grant_s), 0);
    end
    #1 r_valid[0] = 1'b0;
    step();

    // Reset during the second beat of a burst
    do_ar(0, 32'h0000_0000, w, g, sl);
    r_valid[0] = 1'b1; r_last[0] = 1'b0;
    t = 0;
    do begin
      @(negedge clk); t++;
    end while (!r_grant_s[0] && t < 20);
    chk("t6_burst_started", int'(r_grant_s), 2'b01);
    @(negedge clk);
    #2 clr = 1'b0;
    #1;
    chk("t6_rst_ar_grant", int'(ar_grant), 0);
    chk("t6_rst_r_grant_m", int'(r_grant_m), 0);
    chk("t6_rst_r_grant_s", int'(r_grant_s), 0);
    chk("t6_rst_r_msel", int'(r_msel), 0);
    @(negedge clk); #1;
    r_valid[0] = 1'b0;
    clr = 1'b1;
    step();
    do_ar(1, 32'h0002_0000, w, g, sl);
    chk("t6_latency", w, 1);
    chk("t6_grant", g, 3'b010);
    chk("t6_sel", sl, 0);
    r_burst(0, 1, dst, gm, gs, nc); chk("t6_dst", dst, 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
